// File: rtl/bitwise_op_pkg.sv
// Shared opcodes, FSM encodings and id width for the bitwise-op scheduler.
package bitwise_op_pkg;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NAND = 3'b100;
   localparam logic [2:0] OP_NOR  = 3'b101;
   localparam logic [2:0] OP_XNOR = 3'b110;

   localparam int unsigned ID_W = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bitwise_op_unit.sv
// Combinational bitwise operation: f(op, a, b) -> {err, data}.
module bitwise_op_unit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] data,
   output logic             err
);
   import bitwise_op_pkg::*;

   always_comb begin
      data = '0;
      err  = 1'b0;
      case (op)
         OP_AND:  data = a & b;
         OP_OR:   data = a | b;
         OP_XOR:  data = a ^ b;
         OP_NAND: data = ~(a & b);
         OP_NOR:  data = ~(a | b);
         OP_XNOR: data = ~(a ^ b);
         default: err  = 1'b1;
      endcase
   end

endmodule

// File: rtl/bitwise_op_scheduler.sv
// Shares one multi-cycle bitwise unit between NREQ requesters.
// Define BITWISE_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module bitwise_op_scheduler #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned NREQ    = 2,
   parameter int unsigned LATENCY = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*3-1:0]     req_op,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   output logic [2:0]            rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_err,
   output logic                  busy
);
   import bitwise_op_pkg::*;

   localparam int unsigned     CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        op_q;
   logic [WIDTH-1:0]  a_q, b_q, data_q;
   logic              err_q;
   logic [ID_W-1:0]   id_q;

   logic              gnt_found;
   logic [ID_W-1:0]   gnt_idx;
   logic [2:0]        sel_op;
   logic [WIDTH-1:0]  sel_a, sel_b;
   logic [WIDTH-1:0]  unit_data;
   logic              unit_err;

`ifdef BITWISE_ARB_RR_EN
   logic [ID_W-1:0]   last_grant_q;

   // Search starts just after the previous winner and wraps around.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            if (!gnt_found && req_valid[i] &&
                (i == (int'(last_grant_q) + k) % int'(NREQ))) begin
               gnt_found = 1'b1;
               gnt_idx   = ID_W'(i);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_q <= ID_W'(NREQ - 1);
      end else if (state_q == S_IDLE && gnt_found) begin
         last_grant_q <= gnt_idx;
      end
   end
`else
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (!gnt_found && req_valid[i]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_W'(i);
         end
      end
   end
`endif

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (gnt_idx == ID_W'(i)) begin
            sel_op = req_op[3*i +: 3];
            sel_a  = req_a[WIDTH*i +: WIDTH];
            sel_b  = req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         req_ready[i] = rst_n && (state_q == S_IDLE) && gnt_found && (gnt_idx == ID_W'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (gnt_found) state_d = S_EXEC;
         S_EXEC:  if (cnt_q == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (gnt_found) begin
                  op_q  <= sel_op;
                  a_q   <= sel_a;
                  b_q   <= sel_b;
                  id_q  <= gnt_idx;
                  cnt_q <= CNT_LOAD;
               end
            end
            S_EXEC: begin
               if (cnt_q == '0) begin
                  data_q <= unit_data;
                  err_q  <= unit_err;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   bitwise_op_unit #(
      .WIDTH (WIDTH)
   ) u_unit (
      .op   (op_q),
      .a    (a_q),
      .b    (b_q),
      .data (unit_data),
      .err  (unit_err)
   );

   assign rsp_valid = (state_q == S_DONE);
   assign rsp_id    = id_q;
   assign rsp_data  = data_q;
   assign rsp_err   = err_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bitwise_op_scheduler.sv
// Self-checking bench for bitwise_op_scheduler; honours BITWISE_ARB_RR_EN like the DUT.
module tb_bitwise_op_scheduler;
   localparam int WIDTH   = 16;
   localparam int NREQ    = 2;
   localparam int LATENCY = 10;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*3-1:0]     req_op;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic [2:0]            rsp_id;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_err;
   logic                  busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int last_g   = NREQ - 1;

   bitwise_op_scheduler #(
      .WIDTH   (WIDTH),
      .NREQ    (NREQ),
      .LATENCY (LATENCY)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Reference result {err, data}.
   function automatic logic [16:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
      case (op)
         3'd0:    return {1'b0, a & b};
         3'd1:    return {1'b0, a | b};
         3'd2:    return {1'b0, a ^ b};
         3'd4:    return {1'b0, ~(a & b)};
         3'd5:    return {1'b0, ~(a | b)};
         3'd6:    return {1'b0, ~(a ^ b)};
         default: return {1'b1, 16'h0000};
      endcase
   endfunction

   function automatic int exp_grant(input logic [NREQ-1:0] v);
`ifdef BITWISE_ARB_RR_EN
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last_g + k) % NREQ]) return (last_g + k) % NREQ;
      end
`else
      for (int i = 0; i < NREQ; i++) begin
         if (v[i]) return i;
      end
`endif
      return -1;
   endfunction

   task automatic set_req(input int r, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b);
      req_op[3*r +: 3]      = op;
      req_a[WIDTH*r +: WIDTH] = a;
      req_b[WIDTH*r +: WIDTH] = b;
      req_valid[r]          = 1'b1;
   endtask

   task automatic reset_dut();
      rst_n     = 1'b0;
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      last_g = NREQ - 1;
   endtask

   // Called at a negedge; returns the granted index (clamped to 0 on timeout).
   task automatic wait_grant(output int g);
      g = -1;
      for (int t = 0; t < 40; t++) begin
         #1;
         if (req_ready != '0) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            check("ready_onehot", $countones(req_ready), 1);
            check("grant_id", g, exp_grant(req_valid));
            last_g = g;
            return;
         end
         @(negedge clk);
      end
      check("grant_timeout", 0, 1);
      g = 0;
   endtask

   // Called at the negedge of the first cycle after the accept edge.
   task automatic wait_rsp(input int exp_id, input logic [16:0] e);
      int c;
      bit seen = 0;
      bit leak = 0;
      for (c = 1; c <= LATENCY + 5; c++) begin
         if (c > 1) @(negedge clk);
         #1;
         if (rsp_valid) begin
            seen = 1;
            break;
         end
         if (req_ready != '0 || !busy) leak = 1;
      end
      check("rsp_seen", seen, 1);
      check("rsp_latency", c, LATENCY + 1);
      check("rsp_id", rsp_id, exp_id);
      check("rsp_data", rsp_data, e[15:0]);
      check("rsp_err", rsp_err, e[16]);
      check("exec_ready_busy", leak, 0);
      @(negedge clk);
      #1;
      check("rsp_pulse_idle", {rsp_valid, busy}, 2'b00);
   endtask

   task automatic do_op(input int r, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [16:0] e);
      int g;
      set_req(r, op, a, b);
      wait_grant(g);
      @(posedge clk);
      @(negedge clk);
      req_valid[r]            = 1'b0;
      req_a[WIDTH*r +: WIDTH] = 16'($urandom);
      req_b[WIDTH*r +: WIDTH] = 16'($urandom);
      wait_rsp(g, e);
   endtask

   initial begin
      logic [16:0] tbl [8];
      logic [2:0]  op, op1;
      logic [15:0] a, b, a1, b1;
      logic [16:0] e, e1;
      int          g, got, stray;
      int          t [3];

      tbl = '{17'h00001, 17'h0A541, 17'h0A540, 17'h10000,
              17'h0FFFE, 17'h05ABE, 17'h05ABF, 17'h10000};

      // Reset with requests pending: nothing may be granted.
      rst_n     = 1'b0;
      req_op    = NREQ*3'($urandom);
      req_a     = '0;
      req_b     = '0;
      req_valid = '1;
      repeat (3) @(negedge clk);
      #1;
      check("reset_ready", req_ready, '0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_rsp_id", rsp_id, 0);
      check("reset_rsp_data", rsp_data, 0);
      check("reset_rsp_err", rsp_err, 0);
      req_valid = '0;
      rst_n     = 1'b1;
      last_g    = NREQ - 1;
      @(negedge clk);

      do_op(0, 3'b000, 16'h0080, 16'h4922, 17'h00000);

      for (int i = 0; i < 8; i++) begin
         do_op(int'($urandom_range(0, NREQ - 1)), 3'(i), 16'h8101, 16'h2441, tbl[i]);
      end

      for (int i = 0; i < 10; i++) begin
         op = 3'($urandom);
         a  = 16'($urandom);
         b  = 16'($urandom);
         do_op(int'($urandom_range(0, NREQ - 1)), op, a, b, ref_op(op, a, b));
      end

      // Contention from a fresh reset so the round-robin pointer is known.
      reset_dut();
      set_req(0, 3'($urandom), 16'($urandom), 16'($urandom));
      set_req(1, 3'($urandom), 16'($urandom), 16'($urandom));
      for (int k = 0; k < 4; k++) begin
         wait_grant(g);
`ifdef BITWISE_ARB_RR_EN
         check("contend_seq", g, k % 2);
`else
         check("contend_seq", g, 0);
`endif
         e = ref_op(req_op[3*g +: 3], req_a[WIDTH*g +: WIDTH], req_b[WIDTH*g +: WIDTH]);
         @(posedge clk);
         @(negedge clk);
         if (k < 3) set_req(g, 3'($urandom), 16'($urandom), 16'($urandom));
         else req_valid = '0;
         wait_rsp(g, e);
      end

      // Operand hold: scribble req0 inputs during EXEC while req1 waits.
      op = 3'($urandom_range(0, 2));
      a  = 16'($urandom);
      b  = 16'($urandom);
      set_req(0, op, a, b);
      wait_grant(g);
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      req_op[2:0]  = ~op;
      req_a[15:0]  = ~a;
      req_b[15:0]  = ~b;
      op1 = 3'($urandom);
      a1  = 16'($urandom);
      b1  = 16'($urandom);
      set_req(1, op1, a1, b1);
      wait_rsp(0, ref_op(op, a, b));
      wait_grant(g);
      e1 = ref_op(op1, a1, b1);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(1, e1);

      // Reset in the fifth EXEC cycle drops the operation.
      set_req(0, 3'b001, 16'($urandom), 16'($urandom));
      wait_grant(g);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check("midreset_busy", busy, 0);
      check("midreset_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      rst_n  = 1'b1;
      last_g = NREQ - 1;
      stray  = 0;
      repeat (LATENCY + 4) begin
         @(negedge clk);
         if (rsp_valid || busy) stray = 1;
      end
      check("midreset_no_rsp", stray, 0);
      op = 3'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      do_op(1, op, a, b, ref_op(op, a, b));

      // Back-to-back: req1 held valid, responses every LATENCY+2 cycles.
      op = 3'b010;
      a  = 16'($urandom);
      b  = 16'($urandom);
      e  = ref_op(op, a, b);
      set_req(1, op, a, b);
      got = 0;
      t   = '{0, 0, 0};
      for (int n = 0; n < 3 * (LATENCY + 2) + 20 && got < 3; n++) begin
         @(negedge clk);
         #1;
         if (rsp_valid) begin
            t[got] = cyc;
            check("b2b_id", rsp_id, 1);
            check("b2b_data", rsp_data, e[15:0]);
            got++;
            if (got == 3) req_valid = '0;
         end
      end
      last_g = 1;
      check("b2b_count", got, 3);
      check("b2b_gap0", t[1] - t[0], LATENCY + 2);
      check("b2b_gap1", t[2] - t[1], LATENCY + 2);
      repeat (LATENCY + 4) @(negedge clk);
      check("b2b_drained", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
